uart_tx_sched: RTL and testbench

Transmit-side scheduler for the board UART. It arbitrates between two message sources, each offering a payload of up to four bytes, and frames the granted payload with the same SYNC / byte-count / ESC / END protocol the receive decoder understands. It then sequences the frame byte by byte into the UART transmitter through its `ld_tx_data` / `tx_data` / `tx_enable` / `tx_empty` handshake. It sits between message producers (status reporter, message-handler acknowledgements) and the `uart` instance, clocked on the same logic clock as the RX decode path.

---
 rtl/uart_tx_sched_if.sv | 22 ++
 rtl/uart_tx_sched.sv | 159 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// UART transmit handshake bundle: load strobe, byte, enable, empty.
// master drives ld_tx_data/tx_data/tx_enable; slave drives tx_empty.
interface uart_tx_sched_if;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_empty;

  modport master (
    output ld_tx_data,
    output tx_data,
    output tx_enable,
    input  tx_empty
  );

  modport slave (
    input  ld_tx_data,
    input  tx_data,
    input  tx_enable,
    output tx_empty
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-source round-robin UART frame scheduler (SYNC/BCNT/DATA/END, ESC).
// Ports: clk, reset (async low), req/len/data per source, gnt/done
// pulses, busy, and the UART handshake through tx (master modport).
module uart_tx_sched #(
  parameter int         MAXBYTES = 4,
  parameter logic [7:0] SP_SYNC  = 8'h7E,
  parameter logic [7:0] SP_ESC   = 8'hFE,
  parameter logic [7:0] SP_END   = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  len0,
  input  logic [2:0]  len1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        busy,
  uart_tx_sched_if.master tx
);

  typedef enum logic [2:0] {
    IDLE, GRANT, NEXT, LOAD, WAITLO, WAITHI, DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_SYNC, PH_BCNT, PH_DATA, PH_END, PH_FIN
  } phase_t;

  localparam logic [2:0] MAXB = 3'(MAXBYTES);

  state_t      state, nstate;
  phase_t      phase, nphase;
  logic [2:0]  k, nk;
  logic        esc_done;
  logic        owner;
  logic        last;
  logic [2:0]  len_q;
  logic [31:0] data_q;
  logic [7:0]  tx_data_q;

  logic        pick;
  logic [2:0]  sel_len;
  logic [2:0]  clip_len;
  logic [31:0] shifted;
  logic [7:0]  raw;
  logic        esc_now;
  logic [7:0]  out_byte;

  // Both requesting: serve the source that did not go last.
  assign pick     = req1 & (~req0 | ~last);
  assign sel_len  = pick ? len1 : len0;
  assign clip_len = (sel_len > MAXB) ? MAXB : sel_len;

  assign shifted  = data_q << {k[1:0], 3'b000};

  always_comb begin
    raw = SP_END;
    unique case (1'b1)
      phase == PH_SYNC: raw = SP_SYNC;
      phase == PH_BCNT: raw = {5'b0, len_q};
      phase == PH_DATA: raw = shifted[31:24];
      default:          raw = SP_END;
    endcase
  end

  // Only count and payload bytes get an escape prefix, once each.
  assign esc_now  = (phase == PH_BCNT || phase == PH_DATA)
                 && (raw == SP_SYNC || raw == SP_ESC)
                 && !esc_done;
  assign out_byte = esc_now ? SP_ESC : raw;

  always_comb begin
    nphase = phase;
    nk     = k;
    unique case (1'b1)
      phase == PH_SYNC: nphase = PH_BCNT;
      phase == PH_BCNT: begin
        nk     = 3'd0;
        nphase = (len_q == 3'd0) ? PH_END : PH_DATA;
      end
      phase == PH_DATA: begin
        nk     = k + 3'd1;
        nphase = (k + 3'd1 == len_q) ? PH_END : PH_DATA;
      end
      default:          nphase = PH_FIN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:   if (req0 | req1) nstate = GRANT;
      GRANT:  nstate = NEXT;
      NEXT:   if (tx.tx_empty) nstate = LOAD;
      LOAD:   nstate = WAITLO;
      WAITLO: if (!tx.tx_empty) nstate = WAITHI;
      WAITHI: if (tx.tx_empty)
                nstate = (phase == PH_FIN) ? DONE : NEXT;
      DONE:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= PH_SYNC;
      k         <= 3'd0;
      esc_done  <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
      len_q     <= 3'd0;
      data_q    <= 32'd0;
      tx_data_q <= 8'd0;
    end else begin
      if (state == IDLE && (req0 | req1)) begin
        owner  <= pick;
        last   <= pick;
        len_q  <= clip_len;
        data_q <= pick ? data1 : data0;
      end
      if (state == GRANT) begin
        phase    <= PH_SYNC;
        k        <= 3'd0;
        esc_done <= 1'b0;
      end
      if (state == NEXT && tx.tx_empty) begin
        tx_data_q <= out_byte;
        if (esc_now) begin
          esc_done <= 1'b1;
        end else begin
          esc_done <= 1'b0;
          phase    <= nphase;
          k        <= nk;
        end
      end
    end
  end

  assign gnt0  = (state == GRANT) & ~owner;
  assign gnt1  = (state == GRANT) &  owner;
  assign done0 = (state == DONE)  & ~owner;
  assign done1 = (state == DONE)  &  owner;
  assign busy  = (state != IDLE);

  assign tx.tx_enable  = busy;
  assign tx.ld_tx_data = (state == LOAD);
  assign tx.tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: UART responder model,
// frame-level reference model, directed and randomized frames.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [2:0]  len0 = '0, len1 = '0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, done0, done1, busy;

  uart_tx_sched_if ifc();

  uart_tx_sched dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .len0  (len0),
    .len1  (len1),
    .data0 (data0),
    .data1 (data1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy),
    .tx    (ifc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // UART model: after each load, empty goes low for a few cycles.
  int   lo_cnt = 0;
  logic stall = 1'b0;
  bit   rand_lo = 1'b0;

  always @(posedge clk) begin
    if (ifc.ld_tx_data)
      lo_cnt <= rand_lo ? int'($urandom_range(1, 4)) : 3;
    else if (lo_cnt > 0)
      lo_cnt <= lo_cnt - 1;
  end

  assign ifc.tx_empty = !stall && (lo_cnt == 0);

  // Monitor on the falling edge.
  logic [7:0] got_q[$];
  int gnt_q[$];
  int done_q[$];
  int loads = 0;
  bit open = 0;
  int overlap = 0;
  int en_drop = 0;
  int ncyc = 0;
  int gnt_at = 0;
  int first_ld = -1;

  always @(negedge clk) begin
    ncyc++;
    if (ifc.ld_tx_data) begin
      got_q.push_back(ifc.tx_data);
      loads++;
      if (first_ld < 0) first_ld = ncyc;
    end
    if (gnt0 || gnt1) begin
      if (open || (gnt0 && gnt1)) overlap++;
      open = 1;
      gnt_q.push_back(gnt1 ? 1 : 0);
      gnt_at = ncyc;
      first_ld = -1;
    end
    if (done0 || done1) begin
      done_q.push_back(done1 ? 1 : 0);
      open = 0;
    end
    if (open && !ifc.tx_enable) en_drop++;
  end

  // Reference frame: SYNC, count, payload, END; escape count/payload.
  logic [7:0] exp_q[$];

  task automatic push_esc(input logic [7:0] b);
    if (b == 8'h7E || b == 8'hFE) exp_q.push_back(8'hFE);
    exp_q.push_back(b);
  endtask

  task automatic build_exp(input logic [2:0] len, input logic [31:0] d);
    int n;
    n = (len > 3'd4) ? 4 : int'(len);
    exp_q.delete();
    exp_q.push_back(8'h7E);
    push_esc(8'(n));
    for (int i = 0; i < n; i++) push_esc(d[31-8*i -: 8]);
    exp_q.push_back(8'h03);
  endtask

  task automatic clear_mon();
    got_q.delete();
    gnt_q.delete();
    done_q.delete();
    en_drop = 0;
    overlap = 0;
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, " gnt0"}, gnt0, 0);
    chk({tag, " gnt1"}, gnt1, 0);
    chk({tag, " done0"}, done0, 0);
    chk({tag, " done1"}, done1, 0);
    chk({tag, " ld"}, ifc.ld_tx_data, 0);
    chk({tag, " txen"}, ifc.tx_enable, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " txdata"}, ifc.tx_data, 0);
  endtask

  task automatic do_reset();
    req0 = 0;
    req1 = 0;
    reset = 0;
    #1;
    open = 0;
    check_idle_outs("rst");
    repeat (2) @(negedge clk);
    reset = 1;
    clear_mon();
  endtask

  task automatic run_frame(input int src, input logic [2:0] len,
                           input logic [31:0] d, input string tag);
    bit ok;
    clear_mon();
    if (src == 0) begin
      len0 = len; data0 = d; req0 = 1;
    end else begin
      len1 = len; data1 = d; req1 = 1;
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (gnt_q.size() > 0) begin ok = 1; break; end
    end
    chk({tag, " gnt seen"}, ok, 1);
    req0 = 0;
    req1 = 0;
    ok = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      if (done_q.size() > 0) begin ok = 1; break; end
    end
    chk({tag, " done seen"}, ok, 1);
    build_exp(len, d);
    chk({tag, " nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i),
          (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD,
          32'(exp_q[i]));
    chk({tag, " gnt cnt"}, gnt_q.size(), 1);
    chk({tag, " gnt src"},
        (gnt_q.size() > 0) ? gnt_q[0] : -1, src);
    chk({tag, " done src"},
        (done_q.size() == 1) ? done_q[0] : -1, src);
    chk({tag, " txen hold"}, en_drop, 0);
    @(negedge clk); #1;
    chk({tag, " idle"}, busy, 0);
  endtask

  function automatic logic [7:0] rnd_byte();
    unique case ($urandom_range(0, 3))
      0:       return 8'h7E;
      1:       return 8'hFE;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int nld;
    @(negedge clk);
    do_reset();
    @(negedge clk); #1;
    check_idle_outs("post-rst");

    run_frame(0, 3'd2, 32'h4142_0000, "single");
    chk("gnt to load", first_ld - gnt_at, 2);
    run_frame(1, 3'd3, 32'h7EFE_1100, "escape");
    run_frame(0, 3'd0, 32'h7E7E_7E7E, "len0");
    run_frame(1, 3'd7, 32'h0102_0304, "clip");
    run_frame(0, 3'd4, 32'hFE7E_FE7E, "allesc");

    rand_lo = 1;
    for (int t = 0; t < 20; t++) begin
      logic [31:0] d;
      d = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
      run_frame(int'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), d,
                $sformatf("rnd%0d", t));
    end
    rand_lo = 0;

    // Round-robin with both sources held.
    do_reset();
    len0 = 3'd1; data0 = 32'hA0000000;
    len1 = 3'd1; data1 = 32'hB0000000;
    req0 = 1;
    req1 = 1;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done_q.size() >= 4) begin ok = 1; break; end
    end
    req0 = 0;
    req1 = 0;
    chk("rr done4", ok, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr order%0d", i),
          (i < gnt_q.size()) ? gnt_q[i] : -1, i % 2);
    chk("rr overlap", overlap, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rr gnt total", gnt_q.size(), 4);
    chk("rr idle", busy, 0);

    // Stall before first load, then reset mid-frame.
    do_reset();
    stall = 1;
    len0 = 3'd2; data0 = 32'h1234_0000;
    req0 = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (gnt_q.size() > 0) begin ok = 1; break; end
    end
    req0 = 0;
    chk("stall gnt", ok, 1);
    nld = loads;
    repeat (10) @(negedge clk);
    #1;
    chk("stall no load", loads - nld, 0);
    chk("stall busy", busy, 1);
    chk("stall txen", ifc.tx_enable, 1);
    #2;
    reset = 0;
    #1;
    open = 0;
    check_idle_outs("midrst");
    @(negedge clk);
    stall = 0;
    reset = 1;
    run_frame(1, 3'd1, 32'h7E00_0000, "post");
    chk("post first", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD,
        32'h7E);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
